// File: rtl/spectrum_pkg.sv
// ============================================================================
// Module   : spectrum_pkg
// Brief    : Shared types, sizes and helpers for the spectrum bar writer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package spectrum_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COLLECT = 3'd1,
        REQ     = 3'd2,
        WAIT    = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam int COLS     = 16;
    localparam int ROWS     = 16;
    localparam int MAG_W    = 11;
    localparam int HEIGHT_W = 5;

    // Two's-complement magnitude; -512 maps to 10'd512, which is still
    // representable as an unsigned 10-bit value.
    function automatic logic [9:0] abs10(input logic [9:0] v);
        return v[9] ? (~v + 10'd1) : v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/spectrum_peak_bank.sv
// ============================================================================
// Module   : spectrum_peak_bank
// Brief    : Per-column running maximum of sample magnitudes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spectrum_peak_bank
    import spectrum_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_clear,
    input  logic                    i_valid,
    input  logic [3:0]              i_col,
    input  logic [MAG_W-1:0]        i_mag,
    output logic [COLS*MAG_W-1:0]   o_peak_next
);

    // The next-state value is exported so the writer can build row 0 from
    // a frame that includes the sample arriving on the same cycle.
    for (genvar c = 0; c < COLS; c++) begin : g_peak
        logic [MAG_W-1:0] r_peak;
        logic [MAG_W-1:0] w_base;
        logic [MAG_W-1:0] w_next;

        assign w_base = i_clear ? '0 : r_peak;
        assign w_next = (i_valid && (i_col == 4'(c)) && (i_mag > w_base)) ? i_mag : w_base;
        assign o_peak_next[c*MAG_W +: MAG_W] = w_next;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_peak <= '0;
            end else begin
                r_peak <= w_next;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/spectrum_bar_writer.sv
// ============================================================================
// Module   : spectrum_bar_writer
// Brief    : Turns one FFT unload into a 16x16 bar image, written row by row.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spectrum_bar_writer
    import spectrum_pkg::*;
#(
    parameter int SHIFT = 5
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fft_soud,
    input  logic        fft_opd,
    input  logic        fft_eoud,
    input  logic [7:0]  fft_idx,
    input  logic [9:0]  fft_re,
    input  logic [9:0]  fft_im,
    input  logic        set_busy,
    output logic        set_request,
    output logic [3:0]  set_row,
    output logic [15:0] set_value,
    output logic        frame_done,
    output logic        busy
);

    state_t                  r_state;
    logic                    w_start;
    logic                    w_accept;
    logic [MAG_W-1:0]        w_mag;
    logic [COLS*MAG_W-1:0]   w_peak_next;
    logic [3:0]              w_row;
    logic [COLS-1:0]         w_bitmap;
    logic                    w_unused_idx;

    assign w_start      = (r_state == IDLE) && fft_soud && fft_opd;
    assign w_accept     = fft_opd && !fft_idx[7] && (w_start || (r_state == COLLECT));
    assign w_mag        = {1'b0, abs10(fft_re)} + {1'b0, abs10(fft_im)};
    assign w_unused_idx = ^fft_idx[2:0];

    // Row being loaded on this edge: row 0 when leaving collection, else the next row.
    assign w_row = (r_state == WAIT) ? (set_row + 4'd1) : 4'd0;

    spectrum_peak_bank u_peak_bank (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_clear     (w_start),
        .i_valid     (w_accept),
        .i_col       (fft_idx[6:3]),
        .i_mag       (w_mag),
        .o_peak_next (w_peak_next)
    );

    for (genvar c = 0; c < COLS; c++) begin : g_col
        logic [MAG_W-1:0]    w_shifted;
        logic [HEIGHT_W-1:0] w_height;

        assign w_shifted   = w_peak_next[c*MAG_W +: MAG_W] >> SHIFT;
        assign w_height    = (w_shifted >= MAG_W'(ROWS)) ? HEIGHT_W'(ROWS) : HEIGHT_W'(w_shifted);
        assign w_bitmap[c] = (w_height >= (HEIGHT_W'(ROWS) - {1'b0, w_row}));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            set_request <= 1'b0;
            set_row     <= 4'd0;
            set_value   <= 16'd0;
            frame_done  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        busy <= 1'b1;
                        if (fft_eoud) begin
                            set_request <= 1'b1;
                            set_row     <= 4'd0;
                            set_value   <= w_bitmap;
                            r_state     <= REQ;
                        end else begin
                            r_state <= COLLECT;
                        end
                    end
                end
                COLLECT: begin
                    if (fft_eoud) begin
                        set_request <= 1'b1;
                        set_row     <= 4'd0;
                        set_value   <= w_bitmap;
                        r_state     <= REQ;
                    end
                end
                REQ: begin
                    if (set_busy) begin
                        set_request <= 1'b0;
                        r_state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (!set_busy) begin
                        if (set_row == 4'(ROWS - 1)) begin
                            frame_done <= 1'b1;
                            r_state    <= DONE;
                        end else begin
                            set_request <= 1'b1;
                            set_row     <= w_row;
                            set_value   <= w_bitmap;
                            r_state     <= REQ;
                        end
                    end
                end
                DONE: begin
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    set_request <= 1'b0;
                    busy        <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_spectrum_bar_writer.sv
// ============================================================================
// Module   : tb_spectrum_bar_writer
// Brief    : Directed, table-driven bench for spectrum_bar_writer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spectrum_bar_writer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fft_soud = 1'b0;
    logic        fft_opd = 1'b0;
    logic        fft_eoud = 1'b0;
    logic [7:0]  fft_idx = 8'd0;
    logic [9:0]  fft_re = 10'd0;
    logic [9:0]  fft_im = 10'd0;
    logic        set_busy = 1'b0;
    logic        set_request;
    logic [3:0]  set_row;
    logic [15:0] set_value;
    logic        frame_done;
    logic        busy;

    always #5 clk = ~clk;

    spectrum_bar_writer #(.SHIFT(5)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fft_soud    (fft_soud),
        .fft_opd     (fft_opd),
        .fft_eoud    (fft_eoud),
        .fft_idx     (fft_idx),
        .fft_re      (fft_re),
        .fft_im      (fft_im),
        .set_busy    (set_busy),
        .set_request (set_request),
        .set_row     (set_row),
        .set_value   (set_value),
        .frame_done  (frame_done),
        .busy        (busy)
    );

    typedef struct {
        int         bin;
        logic [9:0] re;
        logic [9:0] im;
        int         col;
        int         height;
        string      name;
    } vec_t;

    vec_t        vecs[7];
    int          checks = 0;
    int          errors = 0;
    int          mon_err = 0;
    int          done_cnt = 0;
    logic [3:0]  q_row[$];
    logic [15:0] q_val[$];
    bit          rand_lat = 1'b0;
    logic [9:0]  fr_re[256];
    logic [9:0]  fr_im[256];
    int          exp_h[16];

    // Frame-buffer model: acknowledges each request after 0..5 extra cycles.
    initial begin : responder
        forever begin
            @(posedge clk);
            #1;
            if (set_request && !set_busy) begin
                int lat;
                int hold;
                lat  = rand_lat ? int'($urandom_range(0, 5)) : 0;
                hold = rand_lat ? int'($urandom_range(1, 3)) : 1;
                if (lat > 0) begin
                    repeat (lat) @(posedge clk);
                    #1;
                end
                set_busy = 1'b1;
                repeat (hold) @(posedge clk);
                #1 set_busy = 1'b0;
            end
        end
    end

    // Handshake monitor, sampled on the falling edge.
    initial begin : monitor
        logic        prev_req;
        logic        prev_busy;
        logic [3:0]  prev_row;
        logic [15:0] prev_val;
        prev_req  = 1'b0;
        prev_busy = 1'b0;
        prev_row  = 4'd0;
        prev_val  = 16'd0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_req  = 1'b0;
                prev_busy = 1'b0;
            end else begin
                if (frame_done) done_cnt++;
                if (set_request && !prev_req) begin
                    q_row.push_back(set_row);
                    q_val.push_back(set_value);
                end
                if (set_request && prev_req && (set_row != prev_row || set_value != prev_val)) begin
                    mon_err++;
                    $display("FAIL hold_stable: row %0d value %h, was row %0d value %h",
                             set_row, set_value, prev_row, prev_val);
                end
                if (prev_req && prev_busy && set_request) begin
                    mon_err++;
                    $display("FAIL req_fall: set_request=1 after set_busy seen, required 0");
                end
                if (prev_req && !prev_busy && !set_request) begin
                    mon_err++;
                    $display("FAIL req_early_drop: set_request=0 without set_busy, required 1");
                end
                prev_req  = set_request;
                prev_busy = set_busy;
                prev_row  = set_row;
                prev_val  = set_value;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] exp_bits(input int r);
        logic [15:0] b;
        b = 16'd0;
        for (int c = 0; c < 16; c++) begin
            if (exp_h[c] >= 16 - r) b[c] = 1'b1;
        end
        return b;
    endfunction

    task automatic clear_frame();
        for (int i = 0; i < 256; i++) begin
            fr_re[i] = 10'd0;
            fr_im[i] = 10'd0;
        end
        for (int c = 0; c < 16; c++) exp_h[c] = 0;
    endtask

    task automatic send_frame(input bit expect_req);
        for (int i = 0; i < 256; i++) begin
            @(posedge clk);
            #1;
            fft_soud = (i == 0);
            fft_opd  = 1'b1;
            fft_eoud = (i == 255);
            fft_idx  = 8'(i);
            fft_re   = fr_re[i];
            fft_im   = fr_im[i];
            if (expect_req && i == 255) check("req_before_eoud", 32'(set_request), 32'd0);
        end
        @(posedge clk);
        #1;
        fft_soud = 1'b0;
        fft_opd  = 1'b0;
        fft_eoud = 1'b0;
        fft_idx  = 8'd0;
        fft_re   = 10'd0;
        fft_im   = 10'd0;
        if (expect_req) begin
            check("req_after_eoud", 32'(set_request), 32'd1);
            check("busy_in_frame", 32'(busy), 32'd1);
        end
    endtask

    task automatic wait_rows(input string name, input int target);
        int t;
        t = 0;
        while (q_row.size() < target && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check($sformatf("%s_rows_timeout", name), 32'(t < 3000), 32'd1);
    endtask

    task automatic check_frame(input string name, input int base, input int dbase);
        int t;
        t = 0;
        while (done_cnt < dbase + 1 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check($sformatf("%s_done_timeout", name), 32'(t < 3000), 32'd1);
        repeat (3) @(negedge clk);
        check($sformatf("%s_nreq", name), 32'(q_row.size() - base), 32'd16);
        for (int r = 0; r < 16; r++) begin
            logic [3:0]  arow;
            logic [15:0] aval;
            arow = (base + r < q_row.size()) ? q_row[base + r] : 4'hx;
            aval = (base + r < q_val.size()) ? q_val[base + r] : 16'hxxxx;
            check($sformatf("%s_row%0d_addr", name, r), 32'(arow), 32'(r));
            check($sformatf("%s_row%0d_value", name, r), 32'(aval), 32'(exp_bits(r)));
        end
        check($sformatf("%s_done_count", name), 32'(done_cnt - dbase), 32'd1);
        check($sformatf("%s_idle_busy", name), 32'(busy), 32'd0);
    endtask

    initial begin : main
        int base;
        int dbase;
        int mags[8];

        vecs[0] = '{8,   10'd100, 10'h3C4, 1,  5,  "bin8"};
        vecs[1] = '{0,   10'h200, 10'h200, 0,  16, "saturate"};
        vecs[2] = '{200, 10'h1F4, 10'h1F4, 0,  0,  "upper_half"};
        vecs[3] = '{127, 10'h1FF, 10'd0,   15, 15, "height15"};
        vecs[4] = '{120, 10'h3E1, 10'd0,   15, 0,  "below_step"};
        vecs[5] = '{40,  10'h3F0, 10'd16,  5,  1,  "height1"};
        vecs[6] = '{128, 10'h1FF, 10'h1FF, 0,  0,  "bin128"};

        repeat (3) @(posedge clk);
        #1;
        check("rst_request", 32'(set_request), 32'd0);
        check("rst_row", 32'(set_row), 32'd0);
        check("rst_value", 32'(set_value), 32'd0);
        check("rst_done", 32'(frame_done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        for (int v = 0; v < 7; v++) begin
            clear_frame();
            fr_re[vecs[v].bin] = vecs[v].re;
            fr_im[vecs[v].bin] = vecs[v].im;
            exp_h[vecs[v].col] = vecs[v].height;
            rand_lat = (v % 2) == 1;
            base  = q_row.size();
            dbase = done_cnt;
            send_frame(1'b1);
            check_frame(vecs[v].name, base, dbase);
        end

        // Column 2 keeps the largest of its eight bins.
        rand_lat = 1'b1;
        clear_frame();
        mags = '{32, 64, 128, 256, 224, 192, 160, 96};
        for (int k = 0; k < 8; k++) fr_re[16 + k] = 10'(mags[k]);
        exp_h[2] = 8;
        base  = q_row.size();
        dbase = done_cnt;
        send_frame(1'b1);
        check_frame("peak_col2", base, dbase);

        // One-sample frame: soud and eoud together.
        rand_lat = 1'b0;
        clear_frame();
        exp_h[3] = 4;
        base  = q_row.size();
        dbase = done_cnt;
        @(posedge clk);
        #1;
        fft_soud = 1'b1; fft_opd = 1'b1; fft_eoud = 1'b1;
        fft_idx = 8'd24; fft_re = 10'd0; fft_im = 10'h380;
        @(posedge clk);
        #1;
        fft_soud = 1'b0; fft_opd = 1'b0; fft_eoud = 1'b0;
        fft_idx = 8'd0; fft_im = 10'd0;
        check("single_req_rise", 32'(set_request), 32'd1);
        check_frame("single", base, dbase);

        // A new unload arriving mid-write is dropped entirely.
        rand_lat = 1'b1;
        clear_frame();
        fr_re[8] = 10'd100;
        fr_im[8] = 10'h3C4;
        base  = q_row.size();
        dbase = done_cnt;
        send_frame(1'b1);
        wait_rows("drop", base + 4);
        for (int i = 0; i < 256; i++) begin
            fr_re[i] = 10'h1FF;
            fr_im[i] = 10'h1FF;
        end
        send_frame(1'b0);
        exp_h[1] = 5;
        check_frame("drop", base, dbase);

        clear_frame();
        fr_re[40] = 10'h3F0;
        fr_im[40] = 10'd16;
        exp_h[5] = 1;
        base  = q_row.size();
        dbase = done_cnt;
        send_frame(1'b1);
        check_frame("after_drop", base, dbase);

        // Asynchronous reset while row 7 is being written.
        clear_frame();
        fr_re[127] = 10'h1FF;
        base = q_row.size();
        send_frame(1'b1);
        wait_rows("rst_mid", base + 8);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_request", 32'(set_request), 32'd0);
        check("rst_mid_row", 32'(set_row), 32'd0);
        check("rst_mid_value", 32'(set_value), 32'd0);
        check("rst_mid_done", 32'(frame_done), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (10) @(posedge clk);

        clear_frame();
        fr_re[8] = 10'd100;
        fr_im[8] = 10'h3C4;
        exp_h[1] = 5;
        base  = q_row.size();
        dbase = done_cnt;
        send_frame(1'b1);
        check_frame("after_reset", base, dbase);

        check("handshake_monitor", 32'(mon_err), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
